// File: rtl/decoded_ram_reader.sv
// Streams MSG_LEN bytes out of the decoded-message RAM onto a valid/ready
// port, one RAM read per byte, and flags any byte that is not a lowercase
// letter or a space.
module decoded_ram_reader #(
  parameter int MSG_LEN = 32,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_rden,
  input  logic [7:0]        ram_q,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] byte_index,
  output logic              busy,
  output logic              done,
  output logic              bad_char,
  output logic [2:0]        state_dbg
);

  // Handshake: a byte moves when out_valid and out_ready are both high on a
  // rising clk edge. out_valid never depends on out_ready, and out_data /
  // byte_index hold still while out_valid is high and no handshake has happened.

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_PRESENT = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MSG_LEN - 1);

  logic [2:0]        state;
  logic [2:0]        state_next;
  logic [ADDR_W-1:0] counter;
  logic              start_q;
  logic              start_rise;
  logic              handshake;
  logic              last_byte;
  logic              char_ok;

  assign start_rise = start & ~start_q;
  assign handshake  = out_valid & out_ready;
  assign last_byte  = (counter == LAST_IDX);
  // Allowed alphabet: 'a'..'z' and space.
  assign char_ok    = ((ram_q >= 8'd97) && (ram_q <= 8'd122)) || (ram_q == 8'd32);

  assign ram_address = counter;
  assign ram_rden    = (state == S_ISSUE);
  assign out_valid   = (state == S_PRESENT) || (state == S_HOLD);
  assign busy        = (state == S_ISSUE) || (state == S_WAIT) ||
                       (state == S_PRESENT) || (state == S_HOLD);
  assign done        = (state == S_DONE);
  assign state_dbg   = state;

  // Next-state selection; PRESENT and HOLD share the handshake decision.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (start_rise) state_next = S_ISSUE;
      S_ISSUE:   state_next = S_WAIT;
      S_WAIT:    state_next = S_PRESENT;
      S_PRESENT,
      S_HOLD: begin
        if (handshake) state_next = last_byte ? S_DONE : S_ISSUE;
        else           state_next = S_HOLD;
      end
      S_DONE:    if (!start) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // State register and start edge detector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      start_q <= 1'b0;
    end else begin
      state   <= state_next;
      start_q <= start;
    end
  end

  // Byte counter: cleared when a transfer starts, advanced per accepted byte,
  // never advanced past the last byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter <= '0;
    end else if (state == S_IDLE && start_rise) begin
      counter <= '0;
    end else if (handshake && !last_byte) begin
      counter <= counter + 1'b1;
    end
  end

  // Capture the RAM word one cycle after the read was issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data   <= '0;
      byte_index <= '0;
    end else if (state == S_WAIT) begin
      out_data   <= ram_q;
      byte_index <= counter;
    end
  end

  // Sticky bad-character flag, cleared only when a new transfer starts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bad_char <= 1'b0;
    end else if (state == S_IDLE && start_rise) begin
      bad_char <= 1'b0;
    end else if (state == S_WAIT && !char_ok) begin
      bad_char <= 1'b1;
    end
  end

endmodule
